// File: rtl/inst_rom_responder.sv
// Fetch-side instruction store with 1-cycle registered reads
// and a byte-serial little-endian program loader.
module inst_rom_responder #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst_n,
    input  logic                  ice,
    input  logic [31:0]           iaddr,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    output logic                  addr_err,
    input  logic                  ld_en,
    input  logic                  ld_byte_valid,
    input  logic [7:0]            ld_byte,
    output logic                  ld_busy,
    output logic                  ld_done,
    output logic [ADDR_WIDTH:0]   ld_words
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [1:0]            bcnt;
    logic [23:0]           acc;
    logic [31:0]           mem [DEPTH];

    logic                  enter;
    logic                  leave;
    logic                  take;
    logic                  we;
    logic [31:0]           wdata;
    logic                  fetch;
    logic                  bad;
    logic                  words_sat;
    logic [ADDR_WIDTH-1:0] ridx;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (ld_en) state_nx = LOAD;
            LOAD: if (!ld_en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign enter     = (state == IDLE) && ld_en;
    assign leave     = (state == LOAD) && !ld_en;
    assign take      = (state == LOAD) && ld_en && ld_byte_valid;
    assign words_sat = (ld_words == (ADDR_WIDTH+1)'(DEPTH));
    assign ld_busy   = (state == LOAD);

    // Upper bytes of acc are kept zero so a partial word pads itself.
    always_comb begin
        we    = 1'b0;
        wdata = {8'h00, acc};
        if (take && (bcnt == 2'd3)) begin
            we    = 1'b1;
            wdata = {ld_byte, acc};
        end else if (leave && (bcnt != 2'd0)) begin
            we    = 1'b1;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            ptr      <= '0;
            bcnt     <= '0;
            acc      <= '0;
            ld_words <= '0;
            ld_done  <= 1'b0;
        end else begin
            ld_done <= leave;
            if (enter) begin
                ptr      <= '0;
                bcnt     <= '0;
                acc      <= '0;
                ld_words <= '0;
            end else begin
                if (we) begin
                    ptr <= ptr + ADDR_WIDTH'(1);
                    if (!words_sat) begin
                        ld_words <= ld_words + (ADDR_WIDTH+1)'(1);
                    end
                end
                if (leave) begin
                    bcnt <= '0;
                end else if (take) begin
                    bcnt <= bcnt + 2'd1;
                    unique case (bcnt)
                        2'd0: acc <= {16'h0000, ld_byte};
                        2'd1: acc[15:8] <= ld_byte;
                        2'd2: acc[23:16] <= ld_byte;
                        default: acc <= acc;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (we) begin
            mem[ptr] <= wdata;
        end
    end

    assign fetch = ice && (state == IDLE) && !ld_en;
    assign ridx  = iaddr[ADDR_WIDTH+1:2];
    assign bad   = (|iaddr[1:0]) || (|(iaddr >> (ADDR_WIDTH + 2)));

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            inst       <= '0;
            inst_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            inst_valid <= fetch;
            addr_err   <= fetch && bad;
            inst       <= (fetch && !bad) ? mem[ridx] : 32'h0;
        end
    end

endmodule

// File: tb/tb_inst_rom_responder.sv
// Directed bench for inst_rom_responder: loader sessions,
// table-driven fetch vectors and reset corner cases.
module tb_inst_rom_responder;

    localparam int AW = 10;

    logic          cpu_clk_50M;
    logic          cpu_rst_n;
    logic          ice;
    logic [31:0]   iaddr;
    logic [31:0]   inst;
    logic          inst_valid;
    logic          addr_err;
    logic          ld_en;
    logic          ld_byte_valid;
    logic [7:0]    ld_byte;
    logic          ld_busy;
    logic          ld_done;
    logic [AW:0]   ld_words;

    int checks;
    int failures;

    inst_rom_responder #(.ADDR_WIDTH(AW)) dut (
        .cpu_clk_50M   (cpu_clk_50M),
        .cpu_rst_n     (cpu_rst_n),
        .ice           (ice),
        .iaddr         (iaddr),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .addr_err      (addr_err),
        .ld_en         (ld_en),
        .ld_byte_valid (ld_byte_valid),
        .ld_byte       (ld_byte),
        .ld_busy       (ld_busy),
        .ld_done       (ld_done),
        .ld_words      (ld_words)
    );

    initial cpu_clk_50M = 1'b0;
    always #10 cpu_clk_50M = ~cpu_clk_50M;

    typedef struct {
        logic        ice;
        logic [31:0] addr;
        logic        v;
        logic        e;
        logic [31:0] d;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ld_byte_valid = 1'b1;
        ld_byte = b;
        step();
        ld_byte_valid = 1'b0;
    endtask

    task automatic begin_load();
        ld_en = 1'b1;
        ld_byte_valid = 1'b0;
        step();
    endtask

    task automatic end_load();
        ld_en = 1'b0;
        ld_byte_valid = 1'b0;
        step();
    endtask

    task automatic fetch_chk(input string nm, input logic [31:0] a,
                             input logic [31:0] d, input logic e);
        ice = 1'b1;
        iaddr = a;
        step();
        chk({nm, "_valid"}, {31'b0, inst_valid}, 32'h1);
        chk({nm, "_err"}, {31'b0, addr_err}, {31'b0, e});
        chk({nm, "_inst"}, inst, d);
        ice = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        checks = 0;
        failures = 0;
        cpu_rst_n = 1'b0;
        ice = 1'b0;
        iaddr = '0;
        ld_en = 1'b0;
        ld_byte_valid = 1'b0;
        ld_byte = '0;
        step();
        step();
        chk("rst_inst", inst, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_err", {31'b0, addr_err}, 32'h0);
        chk("rst_busy", {31'b0, ld_busy}, 32'h0);
        chk("rst_done", {31'b0, ld_done}, 32'h0);
        chk("rst_words", 32'(ld_words), 32'h0);
        cpu_rst_n = 1'b1;
        step();

        // Fill 1025 words: pointer wraps, word count saturates.
        begin_load();
        chk("big_busy", {31'b0, ld_busy}, 32'h1);
        for (int i = 0; i <= 1024; i++) begin
            w = 32'hC0DE0000 | 32'(i);
            for (int b = 0; b < 4; b++) begin
                send_byte(w[8*b +: 8]);
            end
        end
        end_load();
        chk("big_words", 32'(ld_words), 32'd1024);
        chk("big_done", {31'b0, ld_done}, 32'h1);
        step();
        chk("big_done_off", {31'b0, ld_done}, 32'h0);
        fetch_chk("wrap_w0", 32'h0, 32'hC0DE0400, 1'b0);
        fetch_chk("last_w", 32'hFFC, 32'hC0DE03FF, 1'b0);

        // Test-plan load with a fetch held active throughout.
        ice = 1'b1;
        iaddr = 32'h0;
        begin_load();
        chk("tp_entry_words", 32'(ld_words), 32'h0);
        chk("tp_entry_valid", {31'b0, inst_valid}, 32'h0);
        w = 32'h24000820;
        for (int b = 0; b < 4; b++) begin
            send_byte(w[8*b +: 8]);
            chk("tp_ld_valid", {31'b0, inst_valid}, 32'h0);
        end
        w = 32'h24090001;
        for (int b = 0; b < 4; b++) begin
            send_byte(w[8*b +: 8]);
            chk("tp_ld_inst", inst, 32'h0);
        end
        end_load();
        chk("tp_exit_valid", {31'b0, inst_valid}, 32'h0);
        chk("tp_exit_busy", {31'b0, ld_busy}, 32'h0);
        chk("tp_done", {31'b0, ld_done}, 32'h1);
        chk("tp_words", 32'(ld_words), 32'd2);
        step();
        chk("tp_done_off", {31'b0, ld_done}, 32'h0);
        chk("tp_first_valid", {31'b0, inst_valid}, 32'h1);
        chk("tp_first_inst", inst, 32'h24000820);

        vt[0]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h24000820};
        vt[1]  = '{1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'h24090001};
        vt[2]  = '{1'b1, 32'h0000_0008, 1'b1, 1'b0, 32'hC0DE0002};
        vt[3]  = '{1'b1, 32'h0000_000C, 1'b1, 1'b0, 32'hC0DE0003};
        vt[4]  = '{1'b1, 32'h0000_0002, 1'b1, 1'b1, 32'h0};
        vt[5]  = '{1'b1, 32'h0000_1000, 1'b1, 1'b1, 32'h0};
        vt[6]  = '{1'b1, 32'h0000_0FFC, 1'b1, 1'b0, 32'hC0DE03FF};
        vt[7]  = '{1'b0, 32'h0000_0008, 1'b0, 1'b0, 32'h0};
        vt[8]  = '{1'b1, 32'h8000_0000, 1'b1, 1'b1, 32'h0};
        vt[9]  = '{1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'hC0DE0004};
        vt[10] = '{1'b1, 32'h0000_0FF9, 1'b1, 1'b1, 32'h0};
        vt[11] = '{1'b1, 32'h0000_0800, 1'b1, 1'b0, 32'hC0DE0200};
        for (int i = 0; i < 12; i++) begin
            ice = vt[i].ice;
            iaddr = vt[i].addr;
            step();
            chk($sformatf("vec%0d_valid", i), {31'b0, inst_valid},
                {31'b0, vt[i].v});
            chk($sformatf("vec%0d_err", i), {31'b0, addr_err},
                {31'b0, vt[i].e});
            chk($sformatf("vec%0d_inst", i), inst, vt[i].d);
        end

        // Async reset while a fetch response is showing.
        cpu_rst_n = 1'b0;
        #2;
        chk("rstf_valid", {31'b0, inst_valid}, 32'h0);
        chk("rstf_inst", inst, 32'h0);
        step();
        cpu_rst_n = 1'b1;
        ice = 1'b1;
        iaddr = 32'h4;
        step();
        chk("rstf_first", inst, 32'h24090001);
        ice = 1'b0;

        // Partial word, plus a byte arriving on the exit edge.
        begin_load();
        for (int b = 0; b < 5; b++) begin
            send_byte(8'h11 + 8'(b));
        end
        ld_en = 1'b0;
        ld_byte_valid = 1'b1;
        ld_byte = 8'h99;
        step();
        ld_byte_valid = 1'b0;
        chk("part_words", 32'(ld_words), 32'd2);
        chk("part_done", {31'b0, ld_done}, 32'h1);
        step();
        fetch_chk("part_w0", 32'h0, 32'h14131211, 1'b0);
        fetch_chk("part_w1", 32'h4, 32'h00000015, 1'b0);

        // Reset in the middle of a load session.
        begin_load();
        for (int b = 0; b < 6; b++) begin
            send_byte(8'h31 + 8'(b));
        end
        chk("rml_busy_pre", {31'b0, ld_busy}, 32'h1);
        chk("rml_words_pre", 32'(ld_words), 32'd1);
        #2;
        cpu_rst_n = 1'b0;
        ld_en = 1'b0;
        #2;
        chk("rml_busy", {31'b0, ld_busy}, 32'h0);
        chk("rml_words", 32'(ld_words), 32'h0);
        step();
        cpu_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rml_no_done", {31'b0, ld_done}, 32'h0);
        end
        fetch_chk("rml_w0", 32'h0, 32'h34333231, 1'b0);
        fetch_chk("rml_w1", 32'h4, 32'h00000015, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_rom_responder.md
# inst_rom_responder

Instruction-memory responder on the fetch interface: the IF stage drives `ice`/`iaddr`, and this block returns the addressed 32-bit instruction word with one cycle of latency. It also has a byte-serial program loader that fills the word array before or between runs. It sits between the IF stage and the ID stage's instruction input, and replaces a bare ROM model with an addressable, checkable, loadable store.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; array holds 2^ADDR_WIDTH 32-bit words (4 KiB at default).
- `cpu_clk_50M`  in  1  system clock; all state updates on the rising edge.
- `cpu_rst_n`  in  1  reset; asynchronous, active-low.
- `ice`  in  1  fetch enable from the IF stage.
- `iaddr`  in  32  fetch byte address from the IF stage.
- `inst`  out  32  fetched instruction, registered.
- `inst_valid`  out  1  `inst` holds the response to the fetch sampled on the previous edge.
- `addr_err`  out  1  the previous fetch was misaligned or out of range.
- `ld_en`  in  1  loader mode request; while high, fetches are not served.
- `ld_byte_valid`  in  1  `ld_byte` is valid this cycle.
- `ld_byte`  in  8  program byte.
- `ld_busy`  out  1  FSM is in LOAD.
- `ld_done`  out  1  one-cycle pulse when a load session ends.
- `ld_words`  out  ADDR_WIDTH+1  words written in the last or current session.

## Operation
- Reset (async assert): `inst`=0, `inst_valid`=0, `addr_err`=0, `ld_busy`=0, `ld_done`=0, `ld_words`=0. FSM goes to IDLE and the byte counter and write pointer clear. Array contents are not cleared.
- Loader FSM has two states: IDLE and LOAD.
  - IDLE→LOAD on any edge with `ld_en`=1. On entry: pointer=0, byte count=0, `ld_words`=0.
  - In LOAD, each `ld_byte_valid`=1 edge accepts one byte. Bytes assemble little-endian: the 1st byte goes to [7:0] and the 4th to [31:24].
  - The 4th byte's edge writes the word at the pointer, then pointer+1, `ld_words`+1, and the byte count returns to 0.
  - The pointer wraps from 2^ADDR_WIDTH−1 to 0. `ld_words` saturates at 2^ADDR_WIDTH.
  - LOAD→IDLE on an edge with `ld_en`=0. A partial word (1–3 bytes) is written zero-padded in the upper bytes and counts in `ld_words`. `ld_done` pulses in the following cycle.
  - If `ld_en`=0 and `ld_byte_valid`=1 arrive together, the byte is ignored.
- Fetch, in IDLE only:
  - Word index = `iaddr`[ADDR_WIDTH+1:2].
  - Error if `iaddr`[1:0]≠0 or `iaddr`[31:ADDR_WIDTH+2]≠0. On error: `inst`=0 (NOP), `addr_err`=1, `inst_valid`=1.
  - Otherwise `inst`=mem[index], `addr_err`=0, `inst_valid`=1.
- `ice`=0, or FSM in LOAD (including the entry edge): `inst`=0, `inst_valid`=0, `addr_err`=0.

## Timing
- Read latency is 1 cycle. `ice`/`iaddr` sampled at edge k produce `inst`/`inst_valid`/`addr_err` valid after edge k, through cycle k+1.
- Fetches back-to-back every cycle are supported, with no stalls.
- A loader write at edge k is visible to a fetch sampled at edge k+2 or later; fetches are blocked in LOAD and the exit edge.
- `ld_busy` rises after the entry edge and falls after the exit edge. `ld_done` is high for exactly one cycle after `ld_busy` falls.
- Reset mid-load: partial bytes are dropped, already-written words are kept, `ld_done` does not pulse, and `ld_words` reads 0.
- Reset mid-fetch: outputs clear immediately (async). The first valid response follows the first sampled fetch after release.

## Test plan
- Load and read back: assert `ld_en`, send bytes 0x20,0x08,0x00,0x24 then 0x01,0x00,0x09,0x24, deassert. Expect `ld_words`=2 and a one-cycle `ld_done`. Then fetch `iaddr`=0x0 and 0x4 → `inst`=0x24000820 and 0x24090001, `inst_valid`=1 one cycle after each.
- Partial word: load 5 bytes 0x11..0x15 and exit. Expect `ld_words`=2 and word1=0x00000015.
- Errors: fetch 0x00000002 → `inst`=0, `addr_err`=1. Fetch 0x00001000 with ADDR_WIDTH=10 → `addr_err`=1. Fetch 0x00000FFC → last word, `addr_err`=0.
- Streaming: `ice`=1 with `iaddr` 0,4,8,… one per cycle → one `inst` per cycle, each lagging by one cycle, no gaps.
- Fetch during load: `ice`=1 with `ld_en`=1 → `inst_valid`=0 and `inst`=0 throughout; valid again the cycle after the first IDLE fetch.
- Reset mid-load: after 6 bytes, pulse `cpu_rst_n` low. Outputs clear asynchronously, no `ld_done`, word0 kept, word1 unchanged from its prior value.
